// File: rtl/dac_segment_encoder.sv
// Segmented current-steering DAC front end: clips and splits a sample code into
// binary and thermometric control words, sequences analog power-up/down, optional DEM rotation.
module dac_segment_encoder #(
  parameter int BIN_W       = 7,
  parameter int THERM_W     = 17,
  parameter int CODE_W      = 12,
  parameter int WAKE_CYCLES = 16,
  parameter int DEM_EN      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               code_valid,
  input  logic [CODE_W-1:0]  code,
  output logic               code_ready,
  output logic [BIN_W-1:0]   datain,
  output logic [BIN_W-1:0]   datainb,
  output logic [THERM_W-1:0] datatherm,
  output logic [THERM_W-1:0] datathermb,
  output logic               pdb,
  output logic               sat,
  output logic               running
);

  localparam int M_W   = CODE_W - BIN_W;
  localparam int PTR_W = $clog2(THERM_W);
  localparam int FS    = (THERM_W + 1) * (2 ** BIN_W) - 1;

  localparam logic [CODE_W-1:0] FS_CODE   = CODE_W'(FS);
  localparam logic [PTR_W:0]    THERM_N   = (PTR_W + 1)'(THERM_W);
  localparam logic [7:0]        WAKE_LAST = 8'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {ST_OFF, ST_WAKE, ST_RUN, ST_DRAIN} state_t;

  state_t     state;
  logic [7:0] cnt;

  // Handshake: a code transfers on a rising edge where code_valid and code_ready
  // are both high; code_ready is only high in RUN and does not depend on code_valid.
  logic xfer;
  logic drain_zero;
  logic quiet;

  assign xfer       = code_valid & code_ready;
  assign drain_zero = (state == ST_DRAIN) && (cnt == 8'd2);
  assign quiet      = (state == ST_OFF) || (state == ST_WAKE) || drain_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_OFF;
      cnt        <= '0;
      pdb        <= 1'b0;
      code_ready <= 1'b0;
      running    <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          if (en) begin
            state <= ST_WAKE;
            pdb   <= 1'b1;
            cnt   <= '0;
          end
        end
        ST_WAKE: begin
          if (!en) begin
            state <= ST_OFF;
            pdb   <= 1'b0;
          end else if (cnt == WAKE_LAST) begin
            state      <= ST_RUN;
            code_ready <= 1'b1;
            running    <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state      <= ST_DRAIN;
            code_ready <= 1'b0;
            running    <= 1'b0;
            cnt        <= '0;
          end
        end
        default: begin
          // Two flush edges, one zero-code edge, then power down; en is ignored here.
          if (cnt == 8'd3) begin
            state <= ST_OFF;
            pdb   <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

  logic              s1_valid;
  logic              s1_sat;
  logic [CODE_W-1:0] s1_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
      s1_code  <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_code <= (code > FS_CODE) ? FS_CODE : code;
        s1_sat  <= (code > FS_CODE);
      end
    end
  end

  logic [M_W-1:0]     s1_m;
  logic [BIN_W-1:0]   s1_b;
  logic [THERM_W-1:0] fill;
  logic [THERM_W-1:0] rot;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   rot_ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W:0]     ptr_sum;
  logic [PTR_W:0]     ptr_wrap;
  logic [PTR_W:0]     idx_sum;
  logic [PTR_W:0]     idx_wrap;
  logic [PTR_W-1:0]   idx;

  assign s1_m = s1_code[CODE_W-1:BIN_W];
  assign s1_b = s1_code[BIN_W-1:0];

  always_comb begin
    fill     = '0;
    rot      = '0;
    idx_sum  = '0;
    idx_wrap = '0;
    idx      = '0;
    rot_ptr  = (DEM_EN != 0) ? ptr : '0;
    for (int i = 0; i < THERM_W; i++) begin
      fill[i] = (i < int'(s1_m));
    end
    // Element i of the LSB-first fill lands at (i + rot_ptr) mod THERM_W.
    for (int i = 0; i < THERM_W; i++) begin
      idx_sum  = (PTR_W + 1)'(i) + {1'b0, rot_ptr};
      idx_wrap = idx_sum - THERM_N;
      idx      = (idx_sum >= THERM_N) ? idx_wrap[PTR_W-1:0] : idx_sum[PTR_W-1:0];
      rot[idx] = fill[i];
    end
    ptr_sum  = {1'b0, ptr} + (PTR_W + 1)'(s1_m);
    ptr_wrap = ptr_sum - THERM_N;
    ptr_next = (ptr_sum >= THERM_N) ? ptr_wrap[PTR_W-1:0] : ptr_sum[PTR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || quiet) begin
      datain     <= '0;
      datainb    <= '1;
      datatherm  <= '0;
      datathermb <= '1;
      sat        <= 1'b0;
    end else if (s1_valid) begin
      datain     <= s1_b;
      datainb    <= ~s1_b;
      datatherm  <= rot;
      datathermb <= ~rot;
      sat        <= s1_sat;
    end else begin
      sat <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state == ST_OFF)) begin
      ptr <= '0;
    end else if (s1_valid && !quiet) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_dac_segment_encoder.sv
// Bench for dac_segment_encoder: two instances (fixed fill and DEM) driven in lockstep,
// scored against an arithmetic model of the code split and element rotation.
module tb_dac_segment_encoder;

  localparam int BIN_W   = 7;
  localparam int THERM_W = 17;
  localparam int CODE_W  = 12;
  localparam int WAKE    = 16;
  localparam int FS      = 2303;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              code_valid;
  logic [CODE_W-1:0] code;

  logic               code_ready0, pdb0, sat0, running0;
  logic [BIN_W-1:0]   datain0, datainb0;
  logic [THERM_W-1:0] datatherm0, datathermb0;
  logic               code_ready1, pdb1, sat1, running1;
  logic [BIN_W-1:0]   datain1, datainb1;
  logic [THERM_W-1:0] datatherm1, datathermb1;

  dac_segment_encoder #(.BIN_W(BIN_W), .THERM_W(THERM_W), .CODE_W(CODE_W),
                        .WAKE_CYCLES(WAKE), .DEM_EN(0)) u_fix (
    .clk(clk), .rst(rst), .en(en), .code_valid(code_valid), .code(code),
    .code_ready(code_ready0), .datain(datain0), .datainb(datainb0),
    .datatherm(datatherm0), .datathermb(datathermb0), .pdb(pdb0),
    .sat(sat0), .running(running0)
  );

  dac_segment_encoder #(.BIN_W(BIN_W), .THERM_W(THERM_W), .CODE_W(CODE_W),
                        .WAKE_CYCLES(WAKE), .DEM_EN(1)) u_dem (
    .clk(clk), .rst(rst), .en(en), .code_valid(code_valid), .code(code),
    .code_ready(code_ready1), .datain(datain1), .datainb(datainb1),
    .datatherm(datatherm1), .datathermb(datathermb1), .pdb(pdb1),
    .sat(sat1), .running(running1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entry: {sat, datain, therm_dem, therm_fixed}
  logic [41:0]        exp_q[$];
  logic [BIN_W-1:0]   last_din;
  logic [THERM_W-1:0] last_t0, last_t1;
  int                 mptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic exp_pdb, input logic exp_run);
    check({tag, ".pdb0"}, pdb0, exp_pdb);
    check({tag, ".pdb1"}, pdb1, exp_pdb);
    check({tag, ".ready0"}, code_ready0, exp_run);
    check({tag, ".ready1"}, code_ready1, exp_run);
    check({tag, ".running0"}, running0, exp_run);
    check({tag, ".running1"}, running1, exp_run);
  endtask

  task automatic check_data(input string tag, input logic [BIN_W-1:0] din,
                            input logic [THERM_W-1:0] t0, input logic [THERM_W-1:0] t1,
                            input logic s);
    logic [BIN_W-1:0]   dinb;
    logic [THERM_W-1:0] t0b, t1b;
    dinb = ~din;
    t0b  = ~t0;
    t1b  = ~t1;
    check({tag, ".datain0"}, datain0, din);
    check({tag, ".datainb0"}, datainb0, dinb);
    check({tag, ".therm0"}, datatherm0, t0);
    check({tag, ".thermb0"}, datathermb0, t0b);
    check({tag, ".sat0"}, sat0, s);
    check({tag, ".datain1"}, datain1, din);
    check({tag, ".datainb1"}, datainb1, dinb);
    check({tag, ".therm1"}, datatherm1, t1);
    check({tag, ".thermb1"}, datathermb1, t1b);
    check({tag, ".sat1"}, sat1, s);
  endtask

  task automatic check_zero(input string tag);
    check_data(tag, '0, '0, '0, 1'b0);
  endtask

  // Reference: clip, split by division, place m unit elements starting at the DEM pointer.
  task automatic model_push(input int c);
    int cc, m, b;
    logic [THERM_W-1:0] t0, t1;
    logic s;
    s  = (c > FS);
    cc = s ? FS : c;
    m  = cc / 128;
    b  = cc % 128;
    t0 = '0;
    t1 = '0;
    for (int k = 0; k < m; k++) begin
      t0[k] = 1'b1;
      t1[(mptr + k) % THERM_W] = 1'b1;
    end
    mptr = (mptr + m) % THERM_W;
    exp_q.push_back({s, 7'(b), t1, t0});
  endtask

  task automatic expect_update(input string tag);
    logic [41:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.queue got=empty expected=entry", tag);
    end else begin
      e        = exp_q.pop_front();
      last_din = e[40:34];
      last_t1  = e[33:17];
      last_t0  = e[16:0];
      check_data(tag, last_din, last_t0, last_t1, e[41]);
    end
  endtask

  task automatic expect_hold(input string tag);
    check_data(tag, last_din, last_t0, last_t1, 1'b0);
  endtask

  task automatic wake();
    mptr = 0;
    en = 1'b1;
    step();
    check_ctrl("wake.pdb_up", 1'b1, 1'b0);
    check_zero("wake.zero");
    for (int k = 1; k < WAKE; k++) begin
      step();
      check("wake.ready_early", code_ready0, 1'b0);
    end
    step();
    check_ctrl("wake.done", 1'b1, 1'b1);
  endtask

  task automatic send_one(input int c, input string tag);
    code_valid = 1'b1;
    code       = CODE_W'(c);
    step();
    code_valid = 1'b0;
    model_push(c);
    step();
    expect_update(tag);
  endtask

  function automatic int pick();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return $urandom_range(FS + 1, 4095);
      1:       return FS;
      2:       return FS + 1;
      3:       return 0;
      default: return $urandom_range(0, FS);
    endcase
  endfunction

  initial begin
    bit pend;
    bit v;
    int c;
    rst = 1'b1; en = 1'b0; code_valid = 1'b0; code = '0;
    mptr = 0; last_din = '0; last_t0 = '0; last_t1 = '0;
    step(); step();
    check_ctrl("reset", 1'b0, 1'b0);
    check_zero("reset");
    rst = 1'b0;
    step();
    check_ctrl("off_idle", 1'b0, 1'b0);

    // Aborted wake-up returns to OFF.
    en = 1'b1;
    step(); step(); step();
    check("abort.pdb_up", pdb0, 1'b1);
    en = 1'b0;
    step();
    check_ctrl("abort", 1'b0, 1'b0);

    wake();
    send_one(1280, "dem1");
    check("dem1.lit0", datatherm0, 32'h003FF);
    check("dem1.lit1", datatherm1, 32'h003FF);
    send_one(1280, "dem2");
    check("dem2.lit0", datatherm0, 32'h003FF);
    check("dem2.lit1", datatherm1, 32'h1FC07);
    send_one(677, "enc");
    check("enc.din", datain0, 32'h25);
    check("enc.dinb", datainb0, 32'h5A);
    check("enc.therm", datatherm0, 32'h0001F);
    check("enc.thermb", datathermb0, 32'h1FFE0);
    check("enc.sat", sat0, 1'b0);
    check("enc.ptr3", datatherm1, 32'h000F8);
    send_one(4095, "sat");
    check("sat.din", datain0, 32'h7F);
    check("sat.therm0", datatherm0, 32'h1FFFF);
    check("sat.therm1", datatherm1, 32'h1FFFF);
    check("sat.pulse", sat0, 1'b1);
    step();
    expect_hold("sat.after");
    send_one(FS, "fs");
    send_one(FS + 1, "fs_plus1");

    // Random stream, back-to-back transfers mixed with idle cycles.
    pend = 1'b0;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = pick();
      code_valid = v;
      code       = CODE_W'(c);
      step();
      if (pend) expect_update("rand");
      else      expect_hold("rand.hold");
      pend = v;
      if (v) model_push(c);
    end
    code_valid = 1'b0;
    step();
    if (pend) expect_update("rand.last");
    else      expect_hold("rand.last");
    check_ctrl("run", 1'b1, 1'b1);

    // Shutdown with a code in flight, plus an en pulse inside DRAIN.
    c = pick();
    code_valid = 1'b1;
    code = CODE_W'(c);
    en = 1'b0;
    step();
    model_push(c);
    code_valid = 1'b0;
    check_ctrl("drain0", 1'b1, 1'b0);
    expect_hold("drain0");
    en = 1'b1;
    step();
    expect_update("drain1");
    check_ctrl("drain1", 1'b1, 1'b0);
    en = 1'b0;
    step();
    expect_hold("drain2");
    check_ctrl("drain2", 1'b1, 1'b0);
    step();
    check_zero("drain3");
    check_ctrl("drain3", 1'b1, 1'b0);
    step();
    check_ctrl("off", 1'b0, 1'b0);
    check_zero("off");
    repeat (3) step();
    check_ctrl("off_hold", 1'b0, 1'b0);
    last_din = '0; last_t0 = '0; last_t1 = '0;

    // DEM pointer restarts from zero after power-down.
    wake();
    send_one(1280, "ptr_reset");
    check("ptr_reset.lit1", datatherm1, 32'h003FF);

    // Reset with a code in flight and en still high.
    code_valid = 1'b1;
    code = CODE_W'(677);
    step();
    code_valid = 1'b0;
    rst = 1'b1;
    step(); step();
    check_ctrl("rst_mid", 1'b0, 1'b0);
    check_zero("rst_mid");
    rst = 1'b0;
    en  = 1'b0;
    step();
    check_ctrl("rst_post", 1'b0, 1'b0);
    check_zero("rst_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
